// File: rtl/trig_emul.sv
// Self-test trigger emulator: issues a programmed LCT train, schedules an L1A per event at the
// selected latency plus a signed offset, and counts the matcher's MATCH/NO_MATCH responses.
module trig_emul #(
  parameter int unsigned NOM_LAT_S  = 128,
  parameter int unsigned NOM_LAT_L  = 500,
  parameter int unsigned XDLY_STEP  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESP_WAIT  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] NTRIG,
  input  logic [7:0]  SPACING,
  input  logic        LAT_12_5US,
  input  logic [1:0]  XL1DLYSET,
  input  logic [2:0]  OFFSET,
  input  logic [1:0]  MODE,
  input  logic        MATCH_IN,
  input  logic        NO_MATCH_IN,
  output logic        LCT,
  output logic        L1A,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] LCT_CNT,
  output logic [15:0] L1A_CNT,
  output logic [15:0] MATCH_CNT,
  output logic [15:0] NOMATCH_CNT
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = $clog2(RESP_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [9:0]  ts_q;
  logic [15:0] ntrig_q;
  logic [7:0]  spacing_q, sp_q;
  logic        lat_l_q;
  logic [1:0]  xdly_q, mode_q;
  logic [2:0]  off_q;
  logic [WW-1:0] wait_q;

  logic [9:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] fifo_cnt_q;

  logic        lct_q, l1a_q;
  logic [15:0] lct_cnt_q, l1a_cnt_q, match_cnt_q, nomatch_cnt_q;

  logic       fifo_empty, fifo_full, pop, push, issue, need_push;
  logic [9:0] lat, target;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
    // Targets are monotonic, so only the head can ever be due.
    pop        = !fifo_empty && (fifo_mem_q[rd_ptr_q] == ts_q);
    need_push  = (mode_q != 2'b01);
    issue      = (state_q == StRun) && (lct_cnt_q != ntrig_q) && (sp_q == 8'd0) &&
                 (!need_push || !fifo_full || pop);
    push       = issue && need_push;
    lat        = (lat_l_q ? 10'(NOM_LAT_L) : 10'(NOM_LAT_S)) + 10'(xdly_q) * 10'(XDLY_STEP);
    target     = ts_q + lat + {{7{off_q[2]}}, off_q};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = StRun;
      StRun:   if (lct_cnt_q == ntrig_q) state_d = StDrain;
      StDrain: if (fifo_empty && (wait_q == WW'(RESP_WAIT - 1))) state_d = StDone;
      StDone:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem_q[wr_ptr_q] <= target;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      ts_q          <= '0;
      ntrig_q       <= '0;
      spacing_q     <= '0;
      sp_q          <= '0;
      lat_l_q       <= 1'b0;
      xdly_q        <= '0;
      off_q         <= '0;
      mode_q        <= '0;
      wait_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      lct_q         <= 1'b0;
      l1a_q         <= 1'b0;
      lct_cnt_q     <= '0;
      l1a_cnt_q     <= '0;
      match_cnt_q   <= '0;
      nomatch_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 10'd1;
      lct_q   <= issue && (mode_q != 2'b10);
      l1a_q   <= pop;

      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      if ((state_q == StIdle) && START) begin
        ntrig_q       <= NTRIG;
        spacing_q     <= SPACING;
        lat_l_q       <= LAT_12_5US;
        xdly_q        <= XL1DLYSET;
        off_q         <= OFFSET;
        mode_q        <= MODE;
        sp_q          <= '0;
        lct_cnt_q     <= '0;
        l1a_cnt_q     <= '0;
        match_cnt_q   <= '0;
        nomatch_cnt_q <= '0;
      end else begin
        if (issue) lct_cnt_q <= sat_inc(lct_cnt_q);
        if (pop)   l1a_cnt_q <= sat_inc(l1a_cnt_q);
        if (state_q != StIdle) begin
          if (MATCH_IN)    match_cnt_q   <= sat_inc(match_cnt_q);
          if (NO_MATCH_IN) nomatch_cnt_q <= sat_inc(nomatch_cnt_q);
        end
        // A stalled issue restarts the spacing timer from the cycle it finally goes out.
        if (issue)              sp_q <= spacing_q;
        else if (sp_q != 8'd0)  sp_q <= sp_q - 8'd1;
      end

      if ((state_q == StDrain) && fifo_empty) wait_q <= wait_q + WW'(1);
      else                                    wait_q <= '0;
    end
  end

  assign LCT         = lct_q;
  assign L1A         = l1a_q;
  assign BUSY        = (state_q == StRun) || (state_q == StDrain);
  assign DONE        = (state_q == StDone);
  assign LCT_CNT     = lct_cnt_q;
  assign L1A_CNT     = l1a_cnt_q;
  assign MATCH_CNT   = match_cnt_q;
  assign NOMATCH_CNT = nomatch_cnt_q;

endmodule

// File: tb/tb_trig_emul.sv
// Directed bench for trig_emul: a scoreboard of expected L1A cycles is filled as LCTs are seen
// (or by the step itself when LCT is masked) and drained as L1As come out.
module tb_trig_emul;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] NTRIG = '0;
  logic [7:0]  SPACING = '0;
  logic        LAT_12_5US = 1'b0;
  logic [1:0]  XL1DLYSET = '0;
  logic [2:0]  OFFSET = '0;
  logic [1:0]  MODE = '0;
  logic        MATCH_IN = 1'b0;
  logic        NO_MATCH_IN = 1'b0;
  logic        LCT, L1A, BUSY, DONE;
  logic [15:0] LCT_CNT, L1A_CNT, MATCH_CNT, NOMATCH_CNT;

  trig_emul dut (
    .CLK(CLK), .RST(RST), .START(START), .NTRIG(NTRIG), .SPACING(SPACING),
    .LAT_12_5US(LAT_12_5US), .XL1DLYSET(XL1DLYSET), .OFFSET(OFFSET), .MODE(MODE),
    .MATCH_IN(MATCH_IN), .NO_MATCH_IN(NO_MATCH_IN), .LCT(LCT), .L1A(L1A), .BUSY(BUSY),
    .DONE(DONE), .LCT_CNT(LCT_CNT), .L1A_CNT(L1A_CNT), .MATCH_CNT(MATCH_CNT),
    .NOMATCH_CNT(NOMATCH_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   sb[$];
  int   lct_t[$];
  int   l1a_t[$];
  int   exp_lat = 128;
  logic auto_push = 1'b1;
  logic stub_nm = 1'b0;
  int   outstanding = 0;
  int   max_out = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor and matcher stub: MATCH_IN answers each L1A, NO_MATCH_IN each LCT when stub_nm.
  always @(negedge CLK) begin
    MATCH_IN    = 1'b0;
    NO_MATCH_IN = 1'b0;
    if (LCT) begin
      lct_t.push_back(cyc);
      if (auto_push) begin
        sb.push_back(cyc + exp_lat);
        outstanding++;
      end
      if (stub_nm) NO_MATCH_IN = 1'b1;
    end
    if (L1A) begin
      l1a_t.push_back(cyc);
      outstanding--;
      if (sb.size() == 0) chk("l1a_unexpected", cyc, -1);
      else                chk("l1a_time", cyc, sb.pop_front());
      if (!stub_nm) MATCH_IN = 1'b1;
    end
    if (outstanding > max_out) max_out = outstanding;
  end

  task automatic clear_logs();
    sb.delete();
    lct_t.delete();
    l1a_t.delete();
    outstanding = 0;
    max_out = 0;
  endtask

  task automatic start_run(input int nt, input int sp, input bit l12, input int xd, input int off,
                           input int md, output int s);
    @(negedge CLK);
    NTRIG = 16'(nt); SPACING = 8'(sp); LAT_12_5US = l12;
    XL1DLYSET = 2'(xd); OFFSET = 3'(off); MODE = 2'(md);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    s = cyc;
    // Scramble the configuration; a latched run must not notice.
    NTRIG = ~NTRIG; SPACING = ~SPACING; LAT_12_5US = ~LAT_12_5US;
    XL1DLYSET = ~XL1DLYSET; OFFSET = ~OFFSET; MODE = ~MODE;
  endtask

  task automatic wait_done(input int bound, output int t);
    int t0;
    t0 = cyc;
    while (!DONE && (cyc - t0) < bound) @(negedge CLK);
    t = cyc;
    chk("done_reached", int'(DONE), 1);
  endtask

  initial begin
    int s, t;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_lct", int'(LCT), 0);
    chk("rst_l1a", int'(L1A), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_lct_cnt", int'(LCT_CNT), 0);
    chk("rst_match_cnt", int'(MATCH_CNT), 0);
    RST = 1'b0;

    // Basic run
    clear_logs(); exp_lat = 128; auto_push = 1'b1; stub_nm = 1'b0;
    start_run(3, 9, 1'b0, 0, 0, 0, s);
    chk("basic_busy", int'(BUSY), 1);
    wait_done(400, t);
    chk("basic_first_lct", lct_t[0], s + 1);
    chk("basic_lct_gap1", lct_t[1] - lct_t[0], 10);
    chk("basic_lct_gap2", lct_t[2] - lct_t[1], 10);
    chk("basic_n_l1a", l1a_t.size(), 3);
    chk("basic_done_time", t, l1a_t[2] + 16);
    chk("basic_lct_cnt", int'(LCT_CNT), 3);
    chk("basic_l1a_cnt", int'(L1A_CNT), 3);
    chk("basic_match_cnt", int'(MATCH_CNT), 3);
    chk("basic_nomatch_cnt", int'(NOMATCH_CNT), 0);
    chk("basic_sb_empty", sb.size(), 0);
    @(negedge CLK);
    chk("basic_idle_busy", int'(BUSY), 0);
    chk("basic_idle_done", int'(DONE), 0);

    // Latency select across the timestamp wrap
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    repeat (600) @(negedge CLK);
    clear_logs(); exp_lat = 546;
    start_run(2, 100, 1'b1, 3, -2, 0, s);
    wait_done(2000, t);
    chk("lat_n_lct", lct_t.size(), 2);
    chk("lat_n_l1a", l1a_t.size(), 2);
    chk("lat_l1a0", l1a_t[0] - lct_t[0], 546);
    chk("lat_l1a_cnt", int'(L1A_CNT), 2);
    chk("lat_sb_empty", sb.size(), 0);

    // FIFO backpressure
    clear_logs(); exp_lat = 128;
    start_run(8, 0, 1'b0, 0, 0, 0, s);
    wait_done(1000, t);
    chk("bp_n_lct", lct_t.size(), 8);
    chk("bp_burst1", lct_t[3] - lct_t[0], 3);
    chk("bp_stall", lct_t[4] - lct_t[0], 128);
    chk("bp_burst2", lct_t[7] - lct_t[4], 3);
    chk("bp_max_outstanding", max_out, 4);
    chk("bp_l1a_cnt", int'(L1A_CNT), 8);
    chk("bp_sb_empty", sb.size(), 0);

    // LCT only
    clear_logs(); auto_push = 1'b0; stub_nm = 1'b1;
    start_run(5, 2, 1'b0, 0, 0, 1, s);
    wait_done(400, t);
    chk("m01_n_lct", lct_t.size(), 5);
    chk("m01_n_l1a", l1a_t.size(), 0);
    chk("m01_l1a_cnt", int'(L1A_CNT), 0);
    chk("m01_nomatch_cnt", int'(NOMATCH_CNT), 5);
    chk("m01_done_time", t, s + 1 + 4 * 3 + 16 + 1);

    // L1A only: the step itself schedules what masked LCTs would have
    clear_logs(); auto_push = 1'b0; stub_nm = 1'b0;
    sb.push_back(0);
    sb.delete();
    start_run(2, 4, 1'b0, 0, 0, 2, s);
    sb.push_back(s + 1 + 128);
    sb.push_back(s + 1 + 5 + 128);
    wait_done(400, t);
    chk("m10_n_lct", lct_t.size(), 0);
    chk("m10_n_l1a", l1a_t.size(), 2);
    chk("m10_lct_cnt", int'(LCT_CNT), 2);
    chk("m10_l1a_cnt", int'(L1A_CNT), 2);
    chk("m10_sb_empty", sb.size(), 0);

    // START while busy is ignored
    clear_logs(); auto_push = 1'b1;
    start_run(2, 3, 1'b0, 0, 0, 0, s);
    repeat (10) @(negedge CLK);
    NTRIG = 16'd7; MODE = 2'b00; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(400, t);
    chk("busy_start_lct_cnt", int'(LCT_CNT), 2);
    chk("busy_start_n_lct", lct_t.size(), 2);
    repeat (5) @(negedge CLK);
    chk("busy_start_idle", int'(BUSY), 0);

    // Reset mid-run with two L1As pending
    clear_logs();
    start_run(2, 10, 1'b0, 0, 0, 0, s);
    repeat (49) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    sb.delete(); l1a_t.delete();
    chk("mrst_busy", int'(BUSY), 0);
    chk("mrst_lct_cnt", int'(LCT_CNT), 0);
    chk("mrst_match_cnt", int'(MATCH_CNT), 0);
    repeat (200) @(negedge CLK);
    chk("mrst_no_l1a", l1a_t.size(), 0);
    chk("mrst_l1a_cnt", int'(L1A_CNT), 0);
    chk("mrst_busy_late", int'(BUSY), 0);

    // NTRIG = 0
    clear_logs();
    start_run(0, 5, 1'b0, 0, 0, 0, s);
    wait_done(100, t);
    chk("nt0_done_time", t, s + 17);
    chk("nt0_n_lct", lct_t.size(), 0);
    chk("nt0_n_l1a", l1a_t.size(), 0);
    chk("nt0_lct_cnt", int'(LCT_CNT), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
